cmos_switch_pair_bank: RTL and testbench
========================================

Name: cmos_switch_pair_bank

Overview:
- Cycle-based behavioural model of a bank of complementary MOS switch pairs (one pmos pull-up to vdd, one nmos pull-down to gnd per bit), for use in logic-gate exercise benches.
- Resolves each bit's output node from the two gate controls and flags contention and floating nodes.
- Holds a floating node's previous value (charge retention).
- In inverter mode, both gates of a bit are tied to one input, giving a CMOS NOT per bit.

Parameters:
- WIDTH, 8: number of independent switch pairs.
- CNT_W, 16: width of the saturating contention-event counter.
- FLOAT_RESET_VAL, 0: value loaded into the retention state at reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- inv_mode  input  1  1: both gates of bit i are driven by a[i]; 0: gate_p/gate_n are used independently.
- a  input  WIDTH  inverter-mode input.
- gate_p  input  WIDTH  pmos gate per bit; the pmos conducts when the gate is 0.
- gate_n  input  WIDTH  nmos gate per bit; the nmos conducts when the gate is 1.
- y  output  WIDTH  resolved node value, registered.
- driven  output  WIDTH  1 = exactly one transistor conducted this evaluation.
- contention  output  WIDTH  1 = both transistors conducted.
- floating  output  WIDTH  1 = neither transistor conducted.
- cont_count  output  CNT_W  saturating count of cycles with any contention bit set.

Behaviour:
- Effective gates per bit:
  - inv_mode=1: pg[i]=ng[i]=a[i].
  - inv_mode=0: pg[i]=gate_p[i], ng[i]=gate_n[i].
- Conduction per bit: pon = ~pg, non = ng.
- Resolution per bit, evaluated combinationally and registered on the rising edge of clk:
  - pon=1, non=0: y<=1; driven<=1; contention<=0; floating<=0.
  - pon=0, non=1: y<=0; driven<=1; contention<=0; floating<=0.
  - pon=0, non=0: y<=previous y (retention); floating<=1; driven<=0; contention<=0.
  - pon=1, non=1: y<=0 (pull-down wins, matching the ratioed-nmos convention); contention<=1; driven<=0; floating<=0.
- Latency: one clock from input change to all outputs. No handshake; a new evaluation occurs every cycle.
- Bits are fully independent; there is no cross-bit interaction.
- In inverter mode, pon and non are always exclusive, so y[i]=~a[i] one cycle later, driven=all ones, and contention and floating are all zeros.
- cont_count:
  - Increments by 1 on each clock where the newly computed contention vector is nonzero.
  - Saturates at 2^CNT_W-1 and does not wrap.
- Reset (rst=1 at a rising edge):
  - y<={WIDTH{FLOAT_RESET_VAL}}.
  - driven, contention, floating <= 0.
  - cont_count<=0.
  - Reset takes priority over evaluation in the same cycle. Reset mid-operation discards retained node values.
- The first evaluation after reset with a floating bit outputs FLOAT_RESET_VAL for that bit.
- X/Z on inputs is not specially handled; the synthesizable 2-state behaviour above is normative.

Test Plan:
- Reset, then inv_mode=1, a=8'h00 -> after 1 clk: y=8'hFF, driven=8'hFF, contention=0, floating=0.
- inv_mode=1, a=8'hFF, then a=8'hA5 on successive clocks -> y=8'h00, then y=8'h5A, each one cycle after its input.
- inv_mode=0, gate_p=8'hFF, gate_n=8'h00 after y=8'h5A -> floating=8'hFF, driven=0, y stays 8'h5A. Then rst=1 -> y=8'h00, all flags 0.
- inv_mode=0, gate_p=8'h00, gate_n=8'h0F -> y=8'hF0, contention=8'h0F, driven=8'hF0, cont_count increments by 1 per cycle held.
- CNT_W=2, hold contention for 5 cycles -> cont_count reads 1,2,3,3,3 (saturates). Then rst -> 0.
- Mixed bits: gate_p=8'b1100_0011, gate_n=8'b1010_0101 -> per bit:
  - pg=1,ng=1 -> y=0, driven.
  - pg=1,ng=0 -> floating, holds previous value.
  - pg=0,ng=1 -> contention, y=0.
  - pg=0,ng=0 -> y=1, driven.
  - Flag vectors must match bitwise.

Source files
------------

// File: rtl/cmos_switch_pair_bank.sv
// ---------------------------------------------------------------------------
// cmos_switch_pair_bank
//
// Cycle-based model of a bank of complementary MOS switch pairs. Each bit has
// one pmos pull-up to vdd and one nmos pull-down to gnd. Every rising clock
// edge, each bit's output node is resolved from its two gate controls, and
// the result is registered together with per-bit status flags.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   inv_mode    1: both gates of bit i follow a[i] (CMOS inverter per bit)
//               0: gate_p / gate_n drive the two transistors independently
//   a           inverter-mode input
//   gate_p      pmos gates (a pmos conducts when its gate is 0)
//   gate_n      nmos gates (an nmos conducts when its gate is 1)
//   y           resolved node values (registered)
//   driven      exactly one transistor of the bit conducted
//   contention  both transistors of the bit conducted
//   floating    neither transistor of the bit conducted
//   cont_count  saturating count of cycles with any contention bit set
// ---------------------------------------------------------------------------
module cmos_switch_pair_bank #(
    parameter int       WIDTH           = 8,
    parameter int       CNT_W           = 16,
    parameter bit       FLOAT_RESET_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inv_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] gate_p,
    input  logic [WIDTH-1:0] gate_n,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] driven,
    output logic [WIDTH-1:0] contention,
    output logic [WIDTH-1:0] floating,
    output logic [CNT_W-1:0] cont_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] y_reg,          y_next;
    logic [WIDTH-1:0] driven_reg,     driven_next;
    logic [WIDTH-1:0] contention_reg, contention_next;
    logic [WIDTH-1:0] floating_reg,   floating_next;
    logic [CNT_W-1:0] cont_count_reg, cont_count_next;

    // Per-bit resolution; bits never interact.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_pair
            logic pg;
            logic ng;
            logic pon;
            logic non;

            assign pg  = inv_mode ? a[gi] : gate_p[gi];
            assign ng  = inv_mode ? a[gi] : gate_n[gi];
            assign pon = ~pg;
            assign non = ng;

            // Pull-down wins under contention (ratioed nmos); with neither
            // device on, the node keeps its stored charge.
            assign y_next[gi]          = non ? 1'b0 : (pon ? 1'b1 : y_reg[gi]);
            assign driven_next[gi]     = pon ^ non;
            assign contention_next[gi] = pon & non;
            assign floating_next[gi]   = ~pon & ~non;
        end
    endgenerate

    always_comb begin
        cont_count_next = cont_count_reg;
        if ((|contention_next) && (cont_count_reg != CNT_MAX)) begin
            cont_count_next = cont_count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_reg          <= {WIDTH{FLOAT_RESET_VAL}};
            driven_reg     <= '0;
            contention_reg <= '0;
            floating_reg   <= '0;
            cont_count_reg <= '0;
        end else begin
            y_reg          <= y_next;
            driven_reg     <= driven_next;
            contention_reg <= contention_next;
            floating_reg   <= floating_next;
            cont_count_reg <= cont_count_next;
        end
    end

    assign y          = y_reg;
    assign driven     = driven_reg;
    assign contention = contention_reg;
    assign floating   = floating_reg;
    assign cont_count = cont_count_reg;

endmodule

// File: tb/tb_cmos_switch_pair_bank.sv
// Bench for cmos_switch_pair_bank: two instances share stimulus, one with the
// default 16-bit counter and one with a 2-bit counter to expose saturation.
module tb_cmos_switch_pair_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inv_mode = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] gate_p = 8'h00;
    logic [7:0] gate_n = 8'h00;

    logic [7:0]  y, driven, contention, floating;
    logic [15:0] cont_count;
    logic [7:0]  y2, driven2, contention2, floating2;
    logic [1:0]  cont_count2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cmos_switch_pair_bank #(.WIDTH(8), .CNT_W(16), .FLOAT_RESET_VAL(1'b0)) dut (
        .clk(clk), .rst(rst), .inv_mode(inv_mode), .a(a),
        .gate_p(gate_p), .gate_n(gate_n),
        .y(y), .driven(driven), .contention(contention),
        .floating(floating), .cont_count(cont_count)
    );

    cmos_switch_pair_bank #(.WIDTH(8), .CNT_W(2), .FLOAT_RESET_VAL(1'b0)) dut_small (
        .clk(clk), .rst(rst), .inv_mode(inv_mode), .a(a),
        .gate_p(gate_p), .gate_n(gate_n),
        .y(y2), .driven(driven2), .contention(contention2),
        .floating(floating2), .cont_count(cont_count2)
    );

    // ---------------- behavioural model ----------------
    // Each bit is classified by how many transistors conduct and which one.
    int m_y[8];
    int m_drv[8];
    int m_con[8];
    int m_flt[8];
    int m_cnt;
    int m_cnt2;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        int pg, ng, pull_up, pull_down, any_con;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_y[i] <= 0; m_drv[i] <= 0; m_con[i] <= 0; m_flt[i] <= 0;
            end
            m_cnt   <= 0;
            m_cnt2  <= 0;
            m_valid <= 1'b1;
        end else begin
            any_con = 0;
            for (int i = 0; i < 8; i++) begin
                pg = inv_mode ? int'(a[i]) : int'(gate_p[i]);
                ng = inv_mode ? int'(a[i]) : int'(gate_n[i]);
                pull_up   = 1 - pg;
                pull_down = ng;
                m_drv[i] <= (pull_up + pull_down == 1) ? 1 : 0;
                m_con[i] <= (pull_up + pull_down == 2) ? 1 : 0;
                m_flt[i] <= (pull_up + pull_down == 0) ? 1 : 0;
                if (pull_down == 1)      m_y[i] <= 0;
                else if (pull_up == 1)   m_y[i] <= 1;
                if (pull_up + pull_down == 2) any_con = 1;
            end
            if (any_con == 1) begin
                m_cnt  <= (m_cnt  + 1 > 65535) ? 65535 : m_cnt + 1;
                m_cnt2 <= (m_cnt2 + 1 > 3)     ? 3     : m_cnt2 + 1;
            end
        end
    end

    function automatic logic [7:0] pack(input int v[8]);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = (v[i] != 0);
        return r;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            cmp("model_y",          int'(y),           int'(pack(m_y)));
            cmp("model_driven",     int'(driven),      int'(pack(m_drv)));
            cmp("model_contention", int'(contention),  int'(pack(m_con)));
            cmp("model_floating",   int'(floating),    int'(pack(m_flt)));
            cmp("model_cont_count", int'(cont_count),  m_cnt);
            cmp("model_y_small",    int'(y2),          int'(pack(m_y)));
            cmp("model_cnt_small",  int'(cont_count2), m_cnt2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [7:0] ey, input logic [7:0] ed,
                       input logic [7:0] ec, input logic [7:0] ef);
        cmp({name, "_y"},          int'(y),          int'(ey));
        cmp({name, "_driven"},     int'(driven),     int'(ed));
        cmp({name, "_contention"}, int'(contention), int'(ec));
        cmp({name, "_floating"},   int'(floating),   int'(ef));
    endtask

    initial begin
        int exp_small[5];
        exp_small = '{1, 2, 3, 3, 3};

        // Reset
        rst = 1'b1;
        tick(); tick();
        lit("reset", 8'h00, 8'h00, 8'h00, 8'h00);
        cmp("reset_cnt", int'(cont_count), 0);
        rst = 1'b0;

        // Inverter mode
        inv_mode = 1'b1; a = 8'h00; tick();
        lit("inv_00", 8'hFF, 8'hFF, 8'h00, 8'h00);
        a = 8'hFF; tick();
        lit("inv_FF", 8'h00, 8'hFF, 8'h00, 8'h00);
        a = 8'hA5; tick();
        lit("inv_A5", 8'h5A, 8'hFF, 8'h00, 8'h00);

        // All floating: retention of 5A
        inv_mode = 1'b0; gate_p = 8'hFF; gate_n = 8'h00; tick();
        lit("float1", 8'h5A, 8'h00, 8'h00, 8'hFF);
        tick();
        lit("float2", 8'h5A, 8'h00, 8'h00, 8'hFF);

        // Reset discards retained value
        rst = 1'b1; tick();
        lit("rst_mid", 8'h00, 8'h00, 8'h00, 8'h00);
        rst = 1'b0; tick();
        lit("float_after_rst", 8'h00, 8'h00, 8'h00, 8'hFF);

        // Contention on low nibble, counters saturate on small instance
        gate_p = 8'h00; gate_n = 8'h0F;
        for (int k = 0; k < 5; k++) begin
            tick();
            lit("cont", 8'hF0, 8'hF0, 8'h0F, 8'h00);
            cmp("cont_cnt",   int'(cont_count),  k + 1);
            cmp("cont_cnt_2", int'(cont_count2), exp_small[k]);
        end

        // Reset has priority over evaluation with contention present
        rst = 1'b1; tick();
        cmp("rst_cnt",   int'(cont_count),  0);
        cmp("rst_cnt_2", int'(cont_count2), 0);
        lit("rst_prio", 8'h00, 8'h00, 8'h00, 8'h00);
        rst = 1'b0;

        // Mixed bits, preloading y=FF so retention is visible
        inv_mode = 1'b1; a = 8'h00; tick();
        lit("preload", 8'hFF, 8'hFF, 8'h00, 8'h00);
        inv_mode = 1'b0; gate_p = 8'b1100_0011; gate_n = 8'b1010_0101; tick();
        lit("mixed", 8'h5A, 8'h99, 8'h24, 8'h42);
        cmp("mixed_cnt", int'(cont_count), 1);

        // No contention: counter holds
        gate_p = 8'hF0; gate_n = 8'hF0; tick();
        lit("split", 8'h0F, 8'hFF, 8'h00, 8'h00);
        cmp("hold_cnt", int'(cont_count), 1);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
